// File: rtl/pulse_gen_if.sv
// Control and strobe bundle between a pulse_gen and its controller.
// The master drives run/step/rate and the slave (pulse_gen) returns the strobes.
interface pulse_gen_if;
   logic       run;
   logic       step_req;
   logic [1:0] rate_sel;
   logic       pulse_1khz;
   logic       pulse_out;
   logic [7:0] pulse_count;

   modport master (
      output run, step_req, rate_sel,
      input  pulse_1khz, pulse_out, pulse_count
   );

   modport slave (
      input  run, step_req, rate_sel,
      output pulse_1khz, pulse_out, pulse_count
   );
endinterface

// File: rtl/pulse_gen.sv
// Millisecond prescaler feeding a selectable-period pulse generator with pause and
// single-step support; every output comes straight from a flop.
module pulse_gen #(
   parameter  int CLK_HZ  = 100_000_000,
   localparam int PRE_DIV = CLK_HZ / 1000
) (
   input logic        clk,
   input logic        reset,
   pulse_gen_if.slave bus
);
   localparam int            PW       = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

   logic [PW-1:0] presc_reg;
   logic [9:0]    ms_cnt_reg;
   logic [1:0]    rate_sel_latched_reg;
   logic          step_d_reg;
   logic          pulse_1khz_reg;
   logic          pulse_out_reg;
   logic [7:0]    pulse_count_reg;

   logic          ms_tick;
   logic          period_end;
   logic          step_edge;
   logic          fire;
   logic [9:0]    period_ms;

   always_comb begin
      ms_tick    = (presc_reg == PRE_LAST);
      period_ms  = 10'd1000 >> rate_sel_latched_reg;
      period_end = ms_tick && bus.run && (ms_cnt_reg == period_ms - 10'd1);
      step_edge  = bus.step_req && !step_d_reg;
      // Masking with the current pulse keeps strobes at least one idle cycle apart
      // and folds a coincident periodic/step event into a single pulse.
      fire       = (period_end || (step_edge && !bus.run)) && !pulse_out_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_reg            <= '0;
         ms_cnt_reg           <= '0;
         rate_sel_latched_reg <= bus.rate_sel;
         // Treat step_req as already high so a level held across reset is not an edge.
         step_d_reg           <= 1'b1;
         pulse_1khz_reg       <= 1'b0;
         pulse_out_reg        <= 1'b0;
         pulse_count_reg      <= '0;
      end else begin
         presc_reg      <= ms_tick ? '0 : presc_reg + PW'(1);
         pulse_1khz_reg <= ms_tick;

         if (ms_tick && bus.run) begin
            if (period_end) begin
               ms_cnt_reg           <= '0;
               rate_sel_latched_reg <= bus.rate_sel;
            end else begin
               ms_cnt_reg <= ms_cnt_reg + 10'd1;
            end
         end

         step_d_reg    <= bus.step_req;
         pulse_out_reg <= fire;
         if (fire) begin
            pulse_count_reg <= pulse_count_reg + 8'd1;
         end
      end
   end

   assign bus.pulse_1khz  = pulse_1khz_reg;
   assign bus.pulse_out   = pulse_out_reg;
   assign bus.pulse_count = pulse_count_reg;
endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen at CLK_HZ=10 kHz: directed timing scenarios plus a random
// segment, all compared every cycle against a millisecond-level reference model.
module tb_pulse_gen;
   localparam int CLK_HZ  = 10_000;
   localparam int PRE_DIV = CLK_HZ / 1000;

   logic clk = 1'b0;
   logic reset;

   pulse_gen_if bus ();

   pulse_gen #(.CLK_HZ(CLK_HZ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pulses_seen = 0;

   // Reference model: elapsed clock edges since reset, elapsed ms in the current period.
   int m_edges;
   int m_ms;
   int m_period;
   bit m_prev_step;
   bit m_1k;
   bit m_pulse;
   int m_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_edge();
      bit ms_tick;
      bit periodic;
      bit stepped;
      if (reset) begin
         m_edges     = 0;
         m_ms        = 0;
         m_period    = 1000 >> bus.rate_sel;
         m_prev_step = 1'b1;
         m_1k        = 1'b0;
         m_pulse     = 1'b0;
         m_count     = 0;
      end else begin
         ms_tick  = ((m_edges + 1) % PRE_DIV) == 0;
         m_edges++;
         periodic = 1'b0;
         if (ms_tick && bus.run) begin
            m_ms++;
            if (m_ms == m_period) begin
               periodic = 1'b1;
               m_ms     = 0;
               m_period = 1000 >> bus.rate_sel;
            end
         end
         stepped     = bus.step_req && !m_prev_step && !bus.run;
         m_prev_step = bus.step_req;
         m_1k        = ms_tick;
         m_pulse     = (periodic || stepped) && !m_pulse;
         if (m_pulse) m_count = (m_count + 1) % 256;
      end
   endtask

   task automatic clk_step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check("pulse_1khz", {31'd0, bus.pulse_1khz}, {31'd0, m_1k});
      check("pulse_out", {31'd0, bus.pulse_out}, {31'd0, m_pulse});
      check("pulse_count", {24'd0, bus.pulse_count}, m_count);
      if (bus.pulse_out === 1'b1) pulses_seen++;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) clk_step();
   endtask

   // Advance until pulse_out is seen (or the budget expires) and check the latency from t0.
   task automatic wait_pulse(input string tag, input int t0, input int limit, input int exp_lat);
      bit got = 1'b0;
      while (!got && (cyc - t0) < limit) begin
         clk_step();
         got = (bus.pulse_out === 1'b1);
      end
      check(tag, got ? (cyc - t0) : -1, exp_lat);
   endtask

   initial begin
      int t0;
      int n0;

      reset        = 1'b1;
      bus.run      = 1'b1;
      bus.rate_sel = 2'd0;
      bus.step_req = 1'b0;
      run_cycles(3);
      check("reset_pulse_out", {31'd0, bus.pulse_out}, 0);
      check("reset_pulse_1khz", {31'd0, bus.pulse_1khz}, 0);
      check("reset_count", {24'd0, bus.pulse_count}, 0);

      // Free-running at 1000 ms
      reset = 1'b0;
      t0 = cyc;
      while (bus.pulse_1khz !== 1'b1 && (cyc - t0) < 20) clk_step();
      check("first_1khz_latency", cyc - t0, PRE_DIV);
      wait_pulse("first_pulse_latency", t0, 10100, 10000);
      check("count_1", {24'd0, bus.pulse_count}, 1);
      wait_pulse("period_2", cyc, 10100, 10000);
      check("count_2", {24'd0, bus.pulse_count}, 2);
      wait_pulse("period_3", cyc, 10100, 10000);
      check("count_3", {24'd0, bus.pulse_count}, 3);

      // Rate change at ms_cnt=400 only applies from the next period
      run_cycles(4000);
      bus.rate_sel = 2'd3;
      wait_pulse("rate_change_finish", cyc, 6100, 6000);
      wait_pulse("rate3_spacing_a", cyc, 1300, 1250);
      wait_pulse("rate3_spacing_b", cyc, 1300, 1250);

      // Step while paused at ms_cnt=50, then resume with a (ignored) step edge
      run_cycles(500);
      bus.run = 1'b0;
      run_cycles(5);
      n0 = pulses_seen;
      bus.step_req = 1'b1;
      wait_pulse("step_latency", cyc, 5, 1);
      run_cycles(49);
      bus.step_req = 1'b0;
      run_cycles(5);
      check("step_single_pulse", pulses_seen - n0, 1);
      bus.run      = 1'b1;
      bus.step_req = 1'b1;
      wait_pulse("resume_after_step", cyc, 800, 750);
      bus.step_req = 1'b0;

      // Pause at ms_cnt=300 for 5000 cycles; 700 ms remain after resume
      bus.rate_sel = 2'd0;
      wait_pulse("latch_rate0", cyc, 1300, 1250);
      run_cycles(3000);
      bus.run = 1'b0;
      n0 = pulses_seen;
      run_cycles(5000);
      check("paused_no_pulse", pulses_seen - n0, 0);
      bus.run = 1'b1;
      wait_pulse("resume_latency", cyc, 7100, 7000);

      // Randomized run/rate/step/reset mix, checked cycle by cycle against the model
      for (int seg = 0; seg < 30; seg++) begin
         if ($urandom_range(0, 9) == 0) begin
            reset = 1'b1;
            run_cycles(2);
            reset = 1'b0;
         end
         bus.run      = 1'($urandom_range(0, 1));
         bus.rate_sel = 2'($urandom_range(0, 3));
         bus.step_req = 1'($urandom_range(0, 1));
         run_cycles($urandom_range(1, 400));
      end

      // step_req held high through reset release, then 256 steps wrap the count
      reset        = 1'b1;
      bus.run      = 1'b0;
      bus.step_req = 1'b1;
      run_cycles(2);
      reset = 1'b0;
      run_cycles(20);
      check("no_pulse_after_reset", {24'd0, bus.pulse_count}, 0);
      n0 = pulses_seen;
      for (int i = 0; i < 256; i++) begin
         bus.step_req = 1'b0;
         run_cycles(2);
         bus.step_req = 1'b1;
         run_cycles(2);
      end
      check("wrap_pulses", pulses_seen - n0, 256);
      check("wrap_count", {24'd0, bus.pulse_count}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz; SHALL be an integer multiple of 1000.
REQ-002 SHALL have parameter PRE_DIV, default CLK_HZ/1000, clock cycles per 1 ms tick (derived; not overridden independently).
REQ-003 SHALL have port clk  input  1  single clock for all logic; all flops on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  1 = free-running pulse generation; 0 = paused.
REQ-006 SHALL have port step_req  input  1  level from a debounced source; a rising edge while paused requests one pulse.
REQ-007 SHALL have port rate_sel  input  2  period select: 0=1000 ms, 1=500 ms, 2=250 ms, 3=125 ms.
REQ-008 SHALL have port pulse_1khz  output  1  free-running one-cycle strobe every PRE_DIV cycles.
REQ-009 SHALL have port pulse_out  output  1  one-cycle strobe that gates the downstream LED rotator (its pulse_1hz enable).
REQ-010 SHALL have port pulse_count  output  8  count of pulse_out strobes emitted, modulo 256.

Function
REQ-011 SHALL implement a prescaler counter 0..PRE_DIV-1; pulse_1khz SHALL be 1 exactly in the cycle after the counter equals PRE_DIV-1, then the counter wraps to 0; run and step_req SHALL NOT affect it.
REQ-012 SHALL hold an active period register, period_ms = 1000 >> rate_sel_latched (1000/500/250/125).
REQ-013 SHALL latch rate_sel into rate_sel_latched only at reset and in the cycle ms_cnt wraps; a mid-period change SHALL take effect only from the next period.
REQ-014 With run=1, ms_cnt SHALL increment on each internal 1 ms tick; on the tick where ms_cnt = period_ms-1, ms_cnt SHALL wrap to 0 and pulse_out SHALL be 1 for exactly the next cycle.
REQ-015 With run=0, ms_cnt SHALL hold its value and no periodic pulse_out SHALL occur; on return to run=1, counting SHALL resume from the held value.
REQ-016 SHALL register step_req into step_d; step edge = step_req & ~step_d, evaluated every cycle.
REQ-017 A step edge with run=0 SHALL produce pulse_out=1 in the following cycle, for exactly 1 cycle, and SHALL leave ms_cnt unchanged.
REQ-018 A step edge with run=1 SHALL be ignored; it SHALL NOT queue a later pulse.
REQ-019 pulse_out SHALL never be high in two consecutive cycles; a coincident periodic and step event SHALL yield one pulse.
REQ-020 pulse_count SHALL increment by 1 in the cycle pulse_out is 1, wrapping 255 -> 0.
REQ-021 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-022 While reset=1 at a clk edge: prescaler=0, ms_cnt=0, pulse_1khz=0, pulse_out=0, pulse_count=0, rate_sel_latched=rate_sel.
REQ-023 Reset SHALL set step_d=1, so a step_req held high through reset release SHALL NOT generate a pulse.
REQ-024 Reset asserted mid-period SHALL discard partial counts; the first periodic pulse after release SHALL occur a full period_ms later.

Verification (CLK_HZ=10_000, so PRE_DIV=10)
REQ-025 reset, run=1, rate_sel=0 -> pulse_1khz every 10 cycles; first pulse_out 10000 cycles after release, then every 10000; pulse_count 1,2,3.
REQ-026 rate_sel 0 -> 3 at ms_cnt=400 -> current period ends at 1000 ms; subsequent pulse_out spacing 1250 cycles.
REQ-027 run=0 at ms_cnt=300, hold 5000 cycles, then run=1 -> no pulse_out while paused; next pulse_out 700 ms (7000 cycles) after resume.
REQ-028 run=0, step_req 0->1 held 50 cycles, then 0 -> exactly one pulse_out, 1 cycle after the rising edge; ms_cnt unchanged; run=1 with step edge -> no extra pulse.
REQ-029 step_req=1 held through reset release -> no pulse_out; 256 steps -> pulse_count wraps to 0.
